// File: rtl/fifo_sram_responder.sv
// Single-port SRAM responder with post-reset zero sweep, 1-cycle registered reads and access counters.
// Optional even-parity storage and checking is enabled by defining SRAM_PARITY_EN.
module fifo_sram_responder #(
  parameter int depth          = 64,
  parameter int sram_datawidth = 128,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                       axis_clk,
  input  logic                       axi_reset_n,
  input  logic                       sram_we,
  input  logic [$clog2(depth)-1:0]   sram_addr,
  input  logic [sram_datawidth-1:0]  sram_din,
`ifdef SRAM_PARITY_EN
  input  logic                       parity_inject,
  output logic                       parity_err,
`endif
  output logic [sram_datawidth-1:0]  sram_dout,
  output logic                       init_done,
  output logic                       access_err,
  output logic [CNT_WIDTH-1:0]       wr_cnt,
  output logic [CNT_WIDTH-1:0]       rd_cnt
);

  localparam int AW = $clog2(depth);
`ifdef SRAM_PARITY_EN
  localparam int MW = sram_datawidth + 1;
`else
  localparam int MW = sram_datawidth;
`endif

  localparam logic [0:0]    ST_INIT  = 1'b0;
  localparam logic [0:0]    ST_READY = 1'b1;
  localparam logic [AW-1:0] LAST_PTR = AW'(depth - 1);
  localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(depth);

  logic [MW-1:0] mem [depth];

  logic [0:0]                state_q, state_d;
  logic [AW-1:0]             initPtr_q, initPtr_d;
  logic [sram_datawidth-1:0] dout_q, dout_d;
  logic                      initDone_q, initDone_d;
  logic                      accessErr_q, accessErr_d;
  logic [CNT_WIDTH-1:0]      wrCnt_q, wrCnt_d;
  logic [CNT_WIDTH-1:0]      rdCnt_q, rdCnt_d;
`ifdef SRAM_PARITY_EN
  logic                      parErr_q, parErr_d;
`endif

  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [MW-1:0] memWdata;
  logic [MW-1:0] memRdata;
  logic [MW-1:0] writeWord;
  logic          inRange;

  // Addresses at or beyond depth exist only when depth is not a power of two.
  assign inRange  = ({1'b0, sram_addr} < DEPTH_L);
  assign memRdata = mem[sram_addr];
`ifdef SRAM_PARITY_EN
  assign writeWord = {(^sram_din) ^ parity_inject, sram_din};
`else
  assign writeWord = sram_din;
`endif

  always_comb begin
    state_d     = state_q;
    initPtr_d   = initPtr_q;
    dout_d      = dout_q;
    initDone_d  = initDone_q;
    accessErr_d = 1'b0;
    wrCnt_d     = wrCnt_q;
    rdCnt_d     = rdCnt_q;
    memWe       = 1'b0;
    memAddr     = sram_addr;
    memWdata    = writeWord;
`ifdef SRAM_PARITY_EN
    parErr_d    = parErr_q;
`endif
    case (state_q)
      ST_INIT: begin
        memWe       = 1'b1;
        memAddr     = initPtr_q;
        memWdata    = '0;
        initPtr_d   = initPtr_q + AW'(1);
        accessErr_d = sram_we;
        if (initPtr_q == LAST_PTR) begin
          state_d    = ST_READY;
          initDone_d = 1'b1;
        end
      end
      default: begin
        if (!inRange) begin
          accessErr_d = 1'b1;
          if (!sram_we) dout_d = '0;
        end else if (sram_we) begin
          memWe = 1'b1;
          if (wrCnt_q != '1) wrCnt_d = wrCnt_q + CNT_WIDTH'(1);
        end else begin
          dout_d = memRdata[sram_datawidth-1:0];
          if (rdCnt_q != '1) rdCnt_d = rdCnt_q + CNT_WIDTH'(1);
`ifdef SRAM_PARITY_EN
          parErr_d = ((^memRdata[sram_datawidth-1:0]) != memRdata[sram_datawidth]);
`endif
        end
      end
    endcase
  end

  // A cycle with reset asserted never touches the array.
  always_ff @(posedge axis_clk) begin
    if (axi_reset_n && memWe) mem[memAddr] <= memWdata;
  end

  always_ff @(posedge axis_clk) begin
    if (!axi_reset_n) begin
      state_q     <= ST_INIT;
      initPtr_q   <= '0;
      dout_q      <= '0;
      initDone_q  <= 1'b0;
      accessErr_q <= 1'b0;
      wrCnt_q     <= '0;
      rdCnt_q     <= '0;
`ifdef SRAM_PARITY_EN
      parErr_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      initPtr_q   <= initPtr_d;
      dout_q      <= dout_d;
      initDone_q  <= initDone_d;
      accessErr_q <= accessErr_d;
      wrCnt_q     <= wrCnt_d;
      rdCnt_q     <= rdCnt_d;
`ifdef SRAM_PARITY_EN
      parErr_q    <= parErr_d;
`endif
    end
  end

  assign sram_dout  = dout_q;
  assign init_done  = initDone_q;
  assign access_err = accessErr_q;
  assign wr_cnt     = wrCnt_q;
  assign rd_cnt     = rdCnt_q;
`ifdef SRAM_PARITY_EN
  assign parity_err = parErr_q;
`endif

endmodule
